fetch_buffer: RTL and testbench

Parametrised fetch stage with a decoupling instruction queue. Issues sequential/predicted instruction-memory reads, buffers returned words with their PCs in a DEPTH-entry FIFO, and presents the head to decode. Redirects on branch misprediction (`correct_target`) or pipeline flush (`correct_pc`), discarding all buffered and in-flight fetches. Replaces the single-register fetch stage.

---
 rtl/fetch_buffer.sv | 106 ++++++++++
 tb/tb_fetch_buffer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch stage with a DEPTH-entry decoupling queue of {pc, instr}.
// Reads are issued from the fetch PC (fpc) and the returned words are queued.
// The head is presented to decode first-word-fall-through. A misprediction or
// flush restarts fetch at a new target and drops everything buffered.
//
// Handshake: imem_ren is the request valid and imem_ihit is the memory's
// ready/accept. A transfer happens only on a cycle where both are high. While
// imem_ren is high and imem_ihit is low, imem_addr is held. An imem_ihit seen
// with imem_ren low is ignored. On the decode side, instr_valid is valid and
// !freeze is ready. A pop happens only when both are high and no redirect is
// in progress.
module fetch_buffer #(
  parameter int                WORD_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic                     CLK,
  input  logic                     nRST,
  output logic                     imem_ren,
  output logic [WORD_W-1:0]        imem_addr,
  input  logic                     imem_ihit,
  input  logic [WORD_W-1:0]        imemload,
  input  logic [WORD_W-1:0]        pc_prediction,
  input  logic                     freeze,
  input  logic                     flush,
  input  logic                     misprediction,
  input  logic [WORD_W-1:0]        correct_target,
  input  logic [WORD_W-1:0]        correct_pc,
  output logic [WORD_W-1:0]        instr,
  output logic [WORD_W-1:0]        pc,
  output logic                     instr_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WORD_W-1:0] fpc;
  logic [WORD_W-1:0] mem_pc    [DEPTH];
  logic [WORD_W-1:0] mem_instr [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;

  logic              redirect;
  logic [WORD_W-1:0] target;
  logic              full;
  logic              push;
  logic              pop;

  // Redirect target: misprediction has priority over flush.
  always_comb begin
    redirect = misprediction | flush;
    target   = misprediction ? correct_target : correct_pc;
  end

  // Request, push/pop qualification and head presentation.
  always_comb begin
    full        = (cnt == CW'(DEPTH));
    imem_ren    = nRST & ~redirect & ~full;
    imem_addr   = fpc;
    push        = imem_ihit & imem_ren;
    instr_valid = (cnt != '0);
    pop         = instr_valid & ~freeze & ~redirect;
    instr       = instr_valid ? mem_instr[rd_ptr] : '0;
    pc          = instr_valid ? mem_pc[rd_ptr]    : '0;
    count       = cnt;
  end

  // Fetch PC, queue pointers and occupancy; redirect drops all queued state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (redirect) begin
      fpc    <= target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        fpc    <= pc_prediction;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Queue storage; contents are don't-care out of reset, so it is not reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_pc[wr_ptr]    <= fpc;
      mem_instr[wr_ptr] <= imemload;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: randomized and directed checks of fetch_buffer against a
// queue-based reference model of the fetch stage.
module tb_fetch_buffer;

  localparam int          W        = 32;
  localparam int          DEPTH    = 4;
  localparam int          CW       = 3;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          CLK;
  logic          nRST;
  logic          imem_ren;
  logic [W-1:0]  imem_addr;
  logic          imem_ihit;
  logic [W-1:0]  imemload;
  logic [W-1:0]  pc_prediction;
  logic          freeze;
  logic          flush;
  logic          misprediction;
  logic [W-1:0]  correct_target;
  logic [W-1:0]  correct_pc;
  logic [W-1:0]  instr;
  logic [W-1:0]  pc;
  logic          instr_valid;
  logic [CW-1:0] count;

  logic [W-1:0]  jump_off;
  int            n_tests;
  int            n_fail;

  // reference model: queue of {pc, instr} plus the model fetch PC
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_fpc;

  fetch_buffer #(.WORD_W(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .nRST(nRST),
    .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_ihit(imem_ihit), .imemload(imemload),
    .pc_prediction(pc_prediction),
    .freeze(freeze), .flush(flush), .misprediction(misprediction),
    .correct_target(correct_target), .correct_pc(correct_pc),
    .instr(instr), .pc(pc), .instr_valid(instr_valid), .count(count)
  );

  // clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // instruction memory content is a fixed function of the address
  function automatic logic [W-1:0] mem_fn(input logic [W-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign imemload      = mem_fn(imem_addr);
  assign pc_prediction = imem_addr + 32'd4 + jump_off;

  wire [100:0] dut_vec = {imem_ren, imem_addr, instr_valid, pc, instr, count};

  // expected {ren, addr, valid, pc, instr, count} from the model
  function automatic logic [100:0] exp_vec();
    logic           ren;
    logic [2*W-1:0] head;
    ren  = nRST && !(flush || misprediction) && (exp_q.size() < DEPTH);
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    return {ren, m_fpc, (exp_q.size() > 0), head[2*W-1:W], head[W-1:0],
            CW'(exp_q.size())};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_fpc = RESET_PC;
  endtask

  // advance model by one clock using the current inputs, then clock the DUT
  task automatic step();
    bit can_req;
    if (!nRST) begin
      model_reset();
    end else if (flush || misprediction) begin
      exp_q.delete();
      m_fpc = misprediction ? correct_target : correct_pc;
    end else begin
      can_req = (exp_q.size() < DEPTH);
      if (exp_q.size() > 0 && !freeze) void'(exp_q.pop_front());
      if (imem_ihit && can_req) begin
        exp_q.push_back({m_fpc, mem_fn(m_fpc)});
        m_fpc = m_fpc + 32'd4 + jump_off;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    imem_ihit      = 1'b0;
    freeze         = 1'b0;
    flush          = 1'b0;
    misprediction  = 1'b0;
    correct_target = '0;
    correct_pc     = '0;
    jump_off       = '0;
  endtask

  task automatic do_reset();
    set_idle();
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    model_reset();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    model_reset();
    #2;
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, exp_vec());
    end
    n_tests++;
    if ({imem_ren, instr_valid, pc, instr, count} !== {1'b0, 1'b0, 32'h0, 32'h0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs ren=%b valid=%b pc=%h instr=%h count=%0d exp all zero",
               imem_ren, instr_valid, pc, instr, count);
    end
    nRST = 1'b1;
    #1;
    n_tests++;
    if (imem_ren !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_request ren=%b addr=%h exp ren=1 addr=%h", imem_ren, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    imem_ihit = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #2;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL stream cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (i >= 1) begin
        n_tests++;
        if (pc !== 32'(4 * (i - 1)) || count !== 3'd1 || instr_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_head cyc=%0d pc=%h count=%0d valid=%b exp pc=%h count=1 valid=1",
                   i, pc, count, instr_valid, 32'(4 * (i - 1)));
        end
      end
      step();
    end
    set_idle();
  endtask

  task automatic test_freeze();
    do_reset();
    imem_ihit = 1'b1;
    freeze    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL freeze_fill cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      step();
    end
    n_tests++;
    if (count !== 3'd4 || imem_ren !== 1'b0 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL freeze_full count=%0d ren=%b pc=%h exp count=4 ren=0 pc=0", count, imem_ren, pc);
    end
    freeze = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #2;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL freeze_drain cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (i < 4) begin
        n_tests++;
        if (pc !== 32'(4 * i)) begin
          n_fail++;
          $display("FAIL drain_order cyc=%0d pc=%h exp=%h", i, pc, 32'(4 * i));
        end
      end
      if (i < 2) begin
        n_tests++;
        if (imem_ren !== (i == 1)) begin
          n_fail++;
          $display("FAIL drain_resume cyc=%0d ren=%b exp=%b", i, imem_ren, (i == 1));
        end
      end
      step();
    end
    set_idle();
  endtask

  task automatic test_mispredict();
    do_reset();
    imem_ihit = 1'b1;
    freeze    = 1'b1;
    repeat (3) step();
    misprediction  = 1'b1;
    correct_target = 32'h100;
    #2;
    n_tests++;
    if (dut_vec !== exp_vec() || count !== 3'd3 || imem_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL mispred_cycle got=%h exp=%h", dut_vec, exp_vec());
    end
    step();
    misprediction = 1'b0;
    #1;
    n_tests++;
    if (instr_valid !== 1'b0 || count !== 3'd0 || imem_addr !== 32'h100 || imem_ren !== 1'b1) begin
      n_fail++;
      $display("FAIL mispred_after valid=%b count=%0d addr=%h ren=%b exp 0 0 100 1",
               instr_valid, count, imem_addr, imem_ren);
    end
    freeze = 1'b0;
    step();
    n_tests++;
    if (instr_valid !== 1'b1 || pc !== 32'h100 || instr !== mem_fn(32'h100)) begin
      n_fail++;
      $display("FAIL mispred_head valid=%b pc=%h instr=%h exp valid=1 pc=100 instr=%h",
               instr_valid, pc, instr, mem_fn(32'h100));
    end
    for (int i = 0; i < 4; i++) begin
      #2;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL mispred_run cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      step();
    end
    set_idle();
  endtask

  task automatic test_both_redirect();
    imem_ihit      = 1'b1;
    flush          = 1'b1;
    misprediction  = 1'b1;
    correct_pc     = 32'h200;
    correct_target = 32'h300;
    step();
    flush         = 1'b0;
    misprediction = 1'b0;
    #1;
    n_tests++;
    if (imem_addr !== 32'h300 || instr_valid !== 1'b0 || imem_ren !== 1'b1) begin
      n_fail++;
      $display("FAIL both_redirect addr=%h valid=%b ren=%b exp addr=300 valid=0 ren=1",
               imem_addr, instr_valid, imem_ren);
    end
    step();
    n_tests++;
    if (dut_vec !== exp_vec() || pc !== 32'h300) begin
      n_fail++;
      $display("FAIL both_head got=%h exp=%h", dut_vec, exp_vec());
    end
    set_idle();
  endtask

  task automatic test_latency();
    logic [W-1:0] prev_addr;
    bit           prev_xfer;
    do_reset();
    prev_xfer = 1'b1;
    prev_addr = '0;
    for (int i = 0; i < 60; i++) begin
      imem_ihit = (i % 3 == 2);
      freeze    = ($urandom_range(0, 3) == 0);
      jump_off  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7) * 4) : 32'h0;
      #2;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL latency cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (!prev_xfer) begin
        n_tests++;
        if (imem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL addr_stable cyc=%0d addr=%h exp=%h", i, imem_addr, prev_addr);
        end
      end
      prev_xfer = imem_ihit && (exp_q.size() < DEPTH);
      prev_addr = m_fpc;
      step();
    end
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      imem_ihit      = ($urandom_range(0, 9) < 7);
      freeze         = ($urandom_range(0, 9) < 3);
      misprediction  = ($urandom_range(0, 19) == 0);
      flush          = ($urandom_range(0, 19) == 0);
      correct_target = 32'($urandom_range(0, 1023) * 4);
      correct_pc     = 32'($urandom_range(0, 1023) * 4);
      jump_off       = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 15) * 4) : 32'h0;
      #2;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      step();
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ihit = 1'b1;
    freeze    = 1'b1;
    repeat (2) step();
    n_tests++;
    if (count !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_pre count=%0d exp=2", count);
    end
    nRST = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (instr_valid !== 1'b0 || count !== 3'd0 || imem_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async valid=%b count=%0d ren=%b exp 0 0 0", instr_valid, count, imem_ren);
    end
    step();
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL mid_hold got=%h exp=%h", dut_vec, exp_vec());
    end
    nRST   = 1'b1;
    freeze = 1'b0;
    #1;
    n_tests++;
    if (imem_addr !== RESET_PC || imem_ren !== 1'b1 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_restart addr=%h ren=%b count=%0d exp addr=%h ren=1 count=0",
               imem_addr, imem_ren, count, RESET_PC);
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_run cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      step();
    end
    set_idle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nRST    = 1'b0;
    set_idle();
    model_reset();
    test_reset();
    test_stream();
    test_freeze();
    test_mispredict();
    test_both_redirect();
    test_latency();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
